// File: rtl/channelizer_power_integrator.sv
`default_nettype none
// ============================================================================
// Module   : channelizer_power_integrator
// Purpose  : Per-channel power integrator for a channelizer output stream.
//            Each accepted beat's power (I*I + Q*Q) is accumulated into a
//            per-channel RAM entry over a configurable number of frames.
//            On the final frame of each period the integrated power is
//            emitted, exactly 4 cycles after the input beat.
// Ports    : Clk, Rst (async, active-low)
//            Enable, Integration_frames            - control / configuration
//            Input_valid/last/index/data           - channelizer stream in
//            Output_valid/last/index/power         - integrated power out
//            Error_sequence                        - 1-cycle sequence error
//            Busy                                  - high while integrating
// Revision : 1.0 - initial release
// ============================================================================
module channelizer_power_integrator #(
    parameter  int NUM_CHANNELS     = 32,
    parameter  int INPUT_DATA_WIDTH = 25,
    parameter  int PERIOD_WIDTH     = 16,
    localparam int IDX_WIDTH        = $clog2(NUM_CHANNELS),
    localparam int POWER_WIDTH      = 2*INPUT_DATA_WIDTH+1,
    localparam int ACCUM_WIDTH      = POWER_WIDTH+PERIOD_WIDTH
) (
    input  logic                                   Clk,
    input  logic                                   Rst,
    input  logic                                   Enable,
    input  logic [PERIOD_WIDTH-1:0]                Integration_frames,
    input  logic                                   Input_valid,
    input  logic                                   Input_last,
    input  logic [IDX_WIDTH-1:0]                   Input_index,
    input  logic [1:0][INPUT_DATA_WIDTH-1:0]       Input_data,
    output logic                                   Output_valid,
    output logic                                   Output_last,
    output logic [IDX_WIDTH-1:0]                   Output_index,
    output logic [ACCUM_WIDTH-1:0]                 Output_power,
    output logic                                   Error_sequence,
    output logic                                   Busy
);

    localparam int                   SQ_WIDTH   = 2*INPUT_DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_INDEX = IDX_WIDTH'(NUM_CHANNELS-1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        INTEGRATE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] frame_q, frame_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [IDX_WIDTH-1:0]    expect_q, expect_d;
    logic                    beat_ok, seq_err, flush;
    logic [PERIOD_WIDTH-1:0] frames_nz;
    logic                    period_end;

    // Stage 1: registered input beat with its frame classification
    logic                        s1_valid_q, s1_last_q, s1_first_q, s1_final_q, s1_err_q;
    logic [IDX_WIDTH-1:0]        s1_index_q;
    logic signed [INPUT_DATA_WIDTH-1:0] s1_i_q, s1_q_q;
    // Stage 2: squares
    logic                        s2_valid_q, s2_last_q, s2_first_q, s2_final_q, s2_err_q;
    logic [IDX_WIDTH-1:0]        s2_index_q;
    logic [SQ_WIDTH-1:0]         s2_ii_q, s2_qq_q;
    // Stage 3: power sum and RAM read data
    logic                        s3_valid_q, s3_last_q, s3_first_q, s3_final_q, s3_err_q;
    logic [IDX_WIDTH-1:0]        s3_index_q;
    logic [POWER_WIDTH-1:0]      s3_power_q;
    logic [ACCUM_WIDTH-1:0]      s3_acc_q;

    logic signed [SQ_WIDTH-1:0]  i_sq, q_sq;
    logic [POWER_WIDTH-1:0]      power;
    logic [ACCUM_WIDTH-1:0]      acc_sum;

    logic [ACCUM_WIDTH-1:0]      acc_ram [NUM_CHANNELS];

    // A period of zero frames is meaningless; treat it as a single frame.
    assign frames_nz  = (Integration_frames == '0) ? PERIOD_WIDTH'(1) : Integration_frames;
    assign period_end = (frame_q == period_q - PERIOD_WIDTH'(1));
    assign Busy       = (state_q == INTEGRATE);

    // Squares of a signed value are non-negative, so the unsigned view is exact.
    assign i_sq    = SQ_WIDTH'(s1_i_q) * SQ_WIDTH'(s1_i_q);
    assign q_sq    = SQ_WIDTH'(s1_q_q) * SQ_WIDTH'(s1_q_q);
    assign power   = POWER_WIDTH'(s2_ii_q) + POWER_WIDTH'(s2_qq_q);
    // First frame of a period overwrites the stale RAM entry instead of adding.
    assign acc_sum = s3_first_q ? ACCUM_WIDTH'(s3_power_q)
                                : s3_acc_q + ACCUM_WIDTH'(s3_power_q);

    // ------------------------------------------------------------------
    // Control: next-state, frame/index tracking, beat qualification
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        period_d = period_q;
        expect_d = expect_q;
        beat_ok  = 1'b0;
        seq_err  = 1'b0;
        flush    = 1'b0;
        if (!Enable) begin
            // Dropping enable abandons the period, including beats in flight.
            state_d  = IDLE;
            frame_d  = '0;
            expect_d = '0;
            flush    = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_SYNC;
                WAIT_SYNC: begin
                    if (Input_valid && Input_last) begin
                        state_d  = INTEGRATE;
                        period_d = frames_nz;
                        frame_d  = '0;
                        expect_d = '0;
                    end
                end
                INTEGRATE: begin
                    if (Input_valid) begin
                        if ((Input_index != expect_q) ||
                            (Input_last && (Input_index != LAST_INDEX))) begin
                            seq_err  = 1'b1;
                            flush    = 1'b1;
                            state_d  = WAIT_SYNC;
                            frame_d  = '0;
                            expect_d = '0;
                        end else begin
                            beat_ok = 1'b1;
                            if (Input_last) begin
                                expect_d = '0;
                                if (period_end) begin
                                    frame_d  = '0;
                                    period_d = frames_nz;
                                end else begin
                                    frame_d = frame_q + PERIOD_WIDTH'(1);
                                end
                            end else begin
                                expect_d = expect_q + IDX_WIDTH'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, pipeline valids and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q        <= IDLE;
            frame_q        <= '0;
            period_q       <= '0;
            expect_q       <= '0;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_first_q     <= 1'b0;
            s1_final_q     <= 1'b0;
            s1_err_q       <= 1'b0;
            s1_index_q     <= '0;
            s1_i_q         <= '0;
            s1_q_q         <= '0;
            s2_valid_q     <= 1'b0;
            s2_last_q      <= 1'b0;
            s2_first_q     <= 1'b0;
            s2_final_q     <= 1'b0;
            s2_err_q       <= 1'b0;
            s2_index_q     <= '0;
            s2_ii_q        <= '0;
            s2_qq_q        <= '0;
            s3_valid_q     <= 1'b0;
            s3_last_q      <= 1'b0;
            s3_first_q     <= 1'b0;
            s3_final_q     <= 1'b0;
            s3_err_q       <= 1'b0;
            s3_index_q     <= '0;
            s3_power_q     <= '0;
            Output_valid   <= 1'b0;
            Output_last    <= 1'b0;
            Output_index   <= '0;
            Output_power   <= '0;
            Error_sequence <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            period_q <= period_d;
            expect_q <= expect_d;

            s1_valid_q <= beat_ok;
            s1_err_q   <= seq_err;
            if (beat_ok) begin
                s1_last_q  <= Input_last;
                s1_first_q <= (frame_q == '0);
                s1_final_q <= period_end;
                s1_index_q <= Input_index;
                s1_i_q     <= Input_data[0];
                s1_q_q     <= Input_data[1];
            end

            s2_valid_q <= s1_valid_q & ~flush;
            s2_err_q   <= s1_err_q;
            if (s1_valid_q) begin
                s2_last_q  <= s1_last_q;
                s2_first_q <= s1_first_q;
                s2_final_q <= s1_final_q;
                s2_index_q <= s1_index_q;
                s2_ii_q    <= $unsigned(i_sq);
                s2_qq_q    <= $unsigned(q_sq);
            end

            s3_valid_q <= s2_valid_q & ~flush;
            s3_err_q   <= s2_err_q;
            if (s2_valid_q) begin
                s3_last_q  <= s2_last_q;
                s3_first_q <= s2_first_q;
                s3_final_q <= s2_final_q;
                s3_index_q <= s2_index_q;
                s3_power_q <= power;
            end

            Output_valid   <= s3_valid_q & s3_final_q & ~flush;
            Output_last    <= s3_valid_q & s3_final_q & s3_last_q & ~flush;
            Error_sequence <= s3_err_q;
            if (s3_valid_q && s3_final_q && !flush) begin
                Output_index <= s3_index_q;
                Output_power <= acc_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator RAM: read in stage 3, write in stage 4. The same channel
    // never recurs within the pipeline depth, so no bypass path exists.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (s3_valid_q && !flush) begin
            acc_ram[s3_index_q] <= acc_sum;
        end
        if (s2_valid_q) begin
            s3_acc_q <= acc_ram[s2_index_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_channelizer_power_integrator.sv
`default_nettype none
// ============================================================================
// Module   : tb_channelizer_power_integrator
// Purpose  : Directed, table-driven bench for channelizer_power_integrator
//            with 8 channels. Each record carries one input beat and the
//            output expected 4 cycles later, hand-derived from I*I+Q*Q.
// Revision : 1.0 - initial release
// ============================================================================
module tb_channelizer_power_integrator;

    localparam int N  = 8;
    localparam int DW = 25;
    localparam int PW = 16;
    localparam int IW = 3;
    localparam int AW = 2*DW+1+PW;

    logic                 Clk;
    logic                 Rst;
    logic                 Enable;
    logic [PW-1:0]        Integration_frames;
    logic                 Input_valid;
    logic                 Input_last;
    logic [IW-1:0]        Input_index;
    logic [1:0][DW-1:0]   Input_data;
    logic                 Output_valid;
    logic                 Output_last;
    logic [IW-1:0]        Output_index;
    logic [AW-1:0]        Output_power;
    logic                 Error_sequence;
    logic                 Busy;

    channelizer_power_integrator #(
        .NUM_CHANNELS     (N),
        .INPUT_DATA_WIDTH (DW),
        .PERIOD_WIDTH     (PW)
    ) dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .Enable             (Enable),
        .Integration_frames (Integration_frames),
        .Input_valid        (Input_valid),
        .Input_last         (Input_last),
        .Input_index        (Input_index),
        .Input_data         (Input_data),
        .Output_valid       (Output_valid),
        .Output_last        (Output_last),
        .Output_index       (Output_index),
        .Output_power       (Output_power),
        .Error_sequence     (Error_sequence),
        .Busy               (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          en;
        int          fr;
        bit          v;
        bit          l;
        int          idx;
        int          di;
        int          dq;
        bit          ev;
        logic [AW-1:0] epow;
        bit          eerr;
        bit          cb;
        bit          eb;
    } vec_t;

    vec_t tbl[$];
    vec_t pipe[4];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic vec_t mk(bit en, int fr, bit v, bit l, int idx, int di, int dq,
                                bit ev, longint ep, bit eerr);
        vec_t r;
        r.en = en; r.fr = fr; r.v = v; r.l = l; r.idx = idx; r.di = di; r.dq = dq;
        r.ev = ev; r.epow = AW'(ep); r.eerr = eerr; r.cb = 1'b0; r.eb = 1'b0;
        return r;
    endfunction

    task automatic add(bit en, int fr, bit v, bit l, int idx, int di, int dq,
                       bit ev, longint ep, bit eerr);
        tbl.push_back(mk(en, fr, v, l, idx, di, dq, ev, ep, eerr));
    endtask

    task automatic add_idle(bit en, int fr, int n);
        for (int k = 0; k < n; k++) add(en, fr, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check Busy just before the most recently added record is driven.
    task automatic mark_busy(bit b);
        tbl[tbl.size()-1].cb = 1'b1;
        tbl[tbl.size()-1].eb = b;
    endtask

    task automatic chk(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(vec_t e);
        bit bad;
        n_vec++;
        bad = (Output_valid !== e.ev) || (Error_sequence !== e.eerr);
        if (e.ev)
            bad = bad || (Output_power !== e.epow) || (Output_index !== IW'(e.idx))
                      || (Output_last !== e.l);
        if (bad) begin
            n_bad++;
            $display("FAIL out cyc=%0d: valid=%b/%b err=%b/%b idx=%0d/%0d last=%b/%b power=%0d/%0d (got/expected)",
                     cyc, Output_valid, e.ev, Error_sequence, e.eerr, Output_index, e.idx,
                     Output_last, e.l, Output_power, e.epow);
        end
    endtask

    task automatic clear_pipe();
        for (int k = 0; k < 4; k++) pipe[k] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check the output due for the beat driven 4 cycles ago,
    // then drive the next beat.
    task automatic cycle(vec_t nv);
        @(negedge Clk);
        cyc++;
        if (nv.cb) begin
            n_vec++;
            if (Busy !== nv.eb) begin
                n_bad++;
                $display("FAIL busy cyc=%0d: got %b, expected %b", cyc, Busy, nv.eb);
            end
        end
        check_out(pipe[3]);
        pipe[3] = pipe[2];
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nv;
        Enable             = nv.en;
        Integration_frames = PW'(nv.fr);
        Input_valid        = nv.v;
        Input_last         = nv.l;
        Input_index        = IW'(nv.idx);
        Input_data[0]      = DW'(nv.di);
        Input_data[1]      = DW'(nv.dq);
    endtask

    task automatic sync_frame(int fr, int d);
        for (int k = 0; k < N; k++) add(1, fr, 1, k == N-1, k, d, -d, 0, 0, 0);
    endtask

    initial begin
        longint p;
        Rst = 1'b0;
        Enable = 1'b0;
        Integration_frames = '0;
        Input_valid = 1'b0;
        Input_last = 1'b0;
        Input_index = '0;
        Input_data = '0;
        clear_pipe();

        // ---------------- table construction ----------------
        // A: period 1, powers k*k+1 then k*k+4 (second frame must overwrite)
        add_idle(0, 1, 2);
        mark_busy(0);
        add_idle(1, 1, 1);
        sync_frame(1, 100);
        mark_busy(0);
        for (int k = 0; k < N; k++) begin
            add(1, 1, 1, k == N-1, k, k, 1, 1, k*k+1, 0);
            if (k == 0) mark_busy(1);
        end
        for (int k = 0; k < N; k++) add(1, 1, 1, k == N-1, k, k, -2, 1, k*k+4, 0);
        add_idle(1, 1, 4);

        // B: Integration_frames = 0 behaves as 1
        add_idle(0, 0, 1);
        add_idle(1, 0, 1);
        sync_frame(0, 5);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) add(1, 0, 1, k == N-1, k, 3, k, 1, 9+k*k, 0);
        add_idle(1, 0, 4);

        // C: period 4 at full scale, one report per period
        p = 64'd4 * (64'd1073741824 + 64'd32767 * 64'd32767);
        add_idle(0, 4, 1);
        add_idle(1, 4, 1);
        sync_frame(4, 7);
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++) add(1, 4, 1, k == N-1, k, -32768, 32767, f == 3, p, 0);
        add_idle(1, 4, 4);

        // D: index 3 skipped -> error, resync on that frame's last beat
        for (int k = 0; k < N; k++) begin
            if (k == 3) continue;
            add(1, 4, 1, k == N-1, k, 50, 50, 0, 0, k == 4);
            if (k == 5) mark_busy(0);
        end
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++) begin
                add(1, 4, 1, k == N-1, k, k, 2, f == 3, 4*(k*k+4), 0);
                if (f == 0 && k == 0) mark_busy(1);
            end

        // E: enable dropped in frame 2, old data must not leak into new period
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) add(1, 4, 1, k == N-1, k, 7, 7, 0, 0, 0);
        for (int k = 0; k < N; k++) begin
            add(k == 3 ? 1'b0 : 1'b1, 4, 1, k == N-1, k, 7, 7, 0, 0, 0);
            if (k == 4) mark_busy(0);
        end
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++) add(1, 4, 1, k == N-1, k, 1, k, f == 3, 4*(1+k*k), 0);
        add_idle(1, 4, 4);

        // ---------------- reset state ----------------
        repeat (2) @(negedge Clk);
        chk("rst_valid", AW'(Output_valid), 0);
        chk("rst_last",  AW'(Output_last), 0);
        chk("rst_index", AW'(Output_index), 0);
        chk("rst_power", Output_power, 0);
        chk("rst_err",   AW'(Error_sequence), 0);
        chk("rst_busy",  AW'(Busy), 0);
        Rst = 1'b1;

        // ---------------- table run ----------------
        foreach (tbl[i]) cycle(tbl[i]);

        // ---------------- F: reset mid-period, back-to-back ----------------
        cycle(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < N; k++) cycle(mk(1, 1, 1, k == N-1, k, 11, 11, 0, 0, 0));
        for (int k = 0; k < 6; k++) cycle(mk(1, 1, 1, 0, k, 2, k, 1, 4+k*k, 0));
        #2 Rst = 1'b0;
        #1;
        chk("mid_rst_valid", AW'(Output_valid), 0);
        chk("mid_rst_last",  AW'(Output_last), 0);
        chk("mid_rst_index", AW'(Output_index), 0);
        chk("mid_rst_power", Output_power, 0);
        chk("mid_rst_busy",  AW'(Busy), 0);
        clear_pipe();
        cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        Rst = 1'b1;
        cycle(mk(1, 1, 1, 0, 6, 9, 9, 0, 0, 0));
        cycle(mk(1, 1, 1, 1, 7, 9, 9, 0, 0, 0));
        for (int k = 0; k < N; k++) begin
            vec_t r;
            r = mk(1, 1, 1, k == N-1, k, 2, k+1, 1, 4+(k+1)*(k+1), 0);
            if (k == 0) begin r.cb = 1'b1; r.eb = 1'b1; end
            cycle(r);
        end
        for (int k = 0; k < 5; k++) cycle(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
